// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard FSM state encoding and EX operand
// forwarding-select codes.
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/reg_match.sv
// Register-specifier comparator: r0 is hardwired zero, so it never
// creates a dependency.
module reg_match #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_match
);

    assign o_match = (i_a != '0) && (i_a == i_b);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: load-use and branch stalls, branch flush,
// multi-cycle memory freeze, EX operand forwarding and a stall counter.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic             mem_req,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output state_t           dbg_state
);

    localparam logic [3:0] LP_LAT = 4'(MEM_LAT);

    state_t           r_state;
    logic [3:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_exrd_rs, w_exrd_rt, w_memrd_rs, w_memrd_rt;
    logic w_memrd_exrs, w_memrd_exrt, w_wbrd_exrs, w_wbrd_exrt;
    logic w_ex_hits_id, w_mem_hits_id, w_load_use, w_branch_stall, w_stall;

    reg_match #(.W(REG_W)) u_exrd_rs    (.i_a(ex_rd),  .i_b(id_rs), .o_match(w_exrd_rs));
    reg_match #(.W(REG_W)) u_exrd_rt    (.i_a(ex_rd),  .i_b(id_rt), .o_match(w_exrd_rt));
    reg_match #(.W(REG_W)) u_memrd_rs   (.i_a(mem_rd), .i_b(id_rs), .o_match(w_memrd_rs));
    reg_match #(.W(REG_W)) u_memrd_rt   (.i_a(mem_rd), .i_b(id_rt), .o_match(w_memrd_rt));
    reg_match #(.W(REG_W)) u_memrd_exrs (.i_a(mem_rd), .i_b(ex_rs), .o_match(w_memrd_exrs));
    reg_match #(.W(REG_W)) u_memrd_exrt (.i_a(mem_rd), .i_b(ex_rt), .o_match(w_memrd_exrt));
    reg_match #(.W(REG_W)) u_wbrd_exrs  (.i_a(wb_rd),  .i_b(ex_rs), .o_match(w_wbrd_exrs));
    reg_match #(.W(REG_W)) u_wbrd_exrt  (.i_a(wb_rd),  .i_b(ex_rt), .o_match(w_wbrd_exrt));

    // rt is only a real source when the ID instruction actually reads it.
    assign w_ex_hits_id   = w_exrd_rs  | (id_uses_rt & w_exrd_rt);
    assign w_mem_hits_id  = w_memrd_rs | (id_uses_rt & w_memrd_rt);
    assign w_load_use     = ex_mem_read & w_ex_hits_id;
    assign w_branch_stall = id_is_branch &
                            ((ex_reg_write & w_ex_hits_id) | (mem_mem_read & w_mem_hits_id));
    assign w_stall        = (r_state == RUN) & (w_load_use | w_branch_stall);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        pipe_hold    = 1'b0;
        if (Reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (r_state == MEM_WAIT) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (w_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            if_id_flush = branch_taken;
        end
    end

    // The youngest producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (!Reset) begin
            if (mem_reg_write && w_memrd_exrs)     fwd_a = FWD_EXMEM;
            else if (wb_reg_write && w_wbrd_exrs)  fwd_a = FWD_MEMWB;
            if (mem_reg_write && w_memrd_exrt)     fwd_b = FWD_EXMEM;
            else if (wb_reg_write && w_wbrd_exrt)  fwd_b = FWD_MEMWB;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= RUN;
            r_wait_cnt    <= 4'd0;
            r_stall_count <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_req && (LP_LAT != 4'd0)) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= LP_LAT;
                    end
                end
                MEM_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt <= 4'd1) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
            if (!pc_write && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver pushes hand-computed expected
// outputs per cycle, a monitor pops and compares them mid-cycle.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam int EW    = 26;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic             id_uses_rt, id_is_branch, branch_taken, ex_reg_write, ex_mem_read;
    logic             mem_reg_write, mem_mem_read, mem_req, wb_reg_write;
    logic             pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_count;
    state_t           dbg_state;

    // Second instance: tiny counter and zero memory latency.
    logic [REG_W-1:0] s_ex_rd, s_id_rs;
    logic             s_ex_mem_read, s_mem_req;
    logic [REG_W-1:0] z_reg = '0;
    logic             z_bit = 1'b0;
    logic             s_pc_write, s_if_id_write, s_bubble, s_flush, s_hold;
    logic [1:0]       s_fwd_a, s_fwd_b, s_stall_count;
    state_t           s_dbg_state;

    logic [EW-1:0] exp_q[$];
    logic [3:0]    exp2_q[$];
    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    hazard_ctrl #(.REG_W(REG_W), .MEM_LAT(2), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .branch_taken(branch_taken), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_req(mem_req),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .pipe_hold(pipe_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count), .dbg_state(dbg_state)
    );

    hazard_ctrl #(.REG_W(REG_W), .MEM_LAT(0), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .id_rs(s_id_rs), .id_rt(z_reg), .id_uses_rt(z_bit),
        .id_is_branch(z_bit), .branch_taken(z_bit), .ex_rs(z_reg), .ex_rt(z_reg),
        .ex_rd(s_ex_rd), .ex_reg_write(z_bit), .ex_mem_read(s_ex_mem_read), .mem_rd(z_reg),
        .mem_reg_write(z_bit), .mem_mem_read(z_bit), .mem_req(s_mem_req),
        .wb_rd(z_reg), .wb_reg_write(z_bit), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .id_ex_bubble(s_bubble), .if_id_flush(s_flush), .pipe_hold(s_hold),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_count(s_stall_count), .dbg_state(s_dbg_state)
    );

    function automatic logic [EW-1:0] ev(input logic pcw, input logic ifw, input logic bub,
                                         input logic fl, input logic hold, input logic [1:0] fa,
                                         input logic [1:0] fb, input logic [CNT_W-1:0] sc,
                                         input state_t st);
        return {pcw, ifw, bub, fl, hold, fa, fb, sc, st};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_uses_rt = 0; id_is_branch = 0; branch_taken = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_reg_write = 0; mem_mem_read = 0; mem_req = 0; wb_reg_write = 0;
    endtask

    // Normal RUN-cycle expectation with given forwarding and count.
    function automatic logic [EW-1:0] ev_run(input logic fl, input logic [1:0] fa,
                                             input logic [1:0] fb, input logic [CNT_W-1:0] sc);
        return ev(1, 1, 0, fl, 0, fa, fb, sc, RUN);
    endfunction

    function automatic logic [EW-1:0] ev_stall(input logic [CNT_W-1:0] sc);
        return ev(0, 0, 1, 0, 0, FWD_REG, FWD_REG, sc, RUN);
    endfunction

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            chk("pc_write",     32'(pc_write),     32'(e[25]));
            chk("if_id_write",  32'(if_id_write),  32'(e[24]));
            chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e[23]));
            chk("if_id_flush",  32'(if_id_flush),  32'(e[22]));
            chk("pipe_hold",    32'(pipe_hold),    32'(e[21]));
            chk("fwd_a",        32'(fwd_a),        32'(e[20:19]));
            chk("fwd_b",        32'(fwd_b),        32'(e[18:17]));
            chk("stall_count",  32'(stall_count),  32'(e[16:1]));
            chk("state",        32'(dbg_state),    32'(e[0]));
        end
        if (exp2_q.size() > 0) begin
            logic [3:0] e2;
            e2 = exp2_q.pop_front();
            chk("sat_pc_write",    32'(s_pc_write),    32'(e2[3]));
            chk("sat_pipe_hold",   32'(s_hold),        32'(e2[2]));
            chk("sat_stall_count", 32'(s_stall_count), 32'(e2[1:0]));
        end
    end

    initial begin
        clr();
        s_ex_rd = '0; s_id_rs = '0; s_ex_mem_read = 0; s_mem_req = 0;
        Reset = 1;
        // Reset cycles, with forwarding-capable inputs that must be masked.
        tick(); clr(); mem_reg_write = 1; mem_rd = 5; ex_rs = 5; ex_mem_read = 1; ex_rd = 8; id_rs = 8;
        exp_q.push_back(ev(0, 0, 1, 1, 0, FWD_REG, FWD_REG, 0, RUN));
        tick(); exp_q.push_back(ev(0, 0, 1, 1, 0, FWD_REG, FWD_REG, 0, RUN));
        tick(); Reset = 0; clr(); exp_q.push_back(ev_run(0, FWD_REG, FWD_REG, 0));
        // Load-use on rs, then on rt (gated by id_uses_rt), and r0 never matches.
        tick(); clr(); ex_mem_read = 1; ex_rd = 8; id_rs = 8; exp_q.push_back(ev_stall(0));
        tick(); clr(); exp_q.push_back(ev_run(0, FWD_REG, FWD_REG, 1));
        tick(); clr(); ex_mem_read = 1; ex_rd = 0; id_rs = 0; exp_q.push_back(ev_run(0, FWD_REG, FWD_REG, 1));
        tick(); clr(); ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1; exp_q.push_back(ev_stall(1));
        tick(); clr(); ex_mem_read = 1; ex_rd = 7; id_rt = 7; exp_q.push_back(ev_run(0, FWD_REG, FWD_REG, 2));
        // Forwarding priorities.
        tick(); clr(); mem_reg_write = 1; mem_rd = 5; wb_reg_write = 1; wb_rd = 5; ex_rs = 5;
        exp_q.push_back(ev_run(0, FWD_EXMEM, FWD_REG, 2));
        tick(); clr(); mem_reg_write = 1; mem_rd = 9; ex_rs = 9; wb_reg_write = 1; wb_rd = 6; ex_rt = 6;
        exp_q.push_back(ev_run(0, FWD_EXMEM, FWD_MEMWB, 2));
        tick(); clr(); mem_rd = 5; ex_rs = 5; wb_reg_write = 1; wb_rd = 5;
        exp_q.push_back(ev_run(0, FWD_MEMWB, FWD_REG, 2));
        // Branch stall beats flush; flush once the hazard clears.
        tick(); clr(); id_is_branch = 1; ex_reg_write = 1; ex_rd = 3; id_rt = 3; id_uses_rt = 1; branch_taken = 1;
        exp_q.push_back(ev_stall(2));
        tick(); clr(); id_is_branch = 1; ex_reg_write = 1; id_rt = 3; id_uses_rt = 1; branch_taken = 1;
        exp_q.push_back(ev_run(1, FWD_REG, FWD_REG, 3));
        tick(); clr(); id_is_branch = 1; mem_mem_read = 1; mem_rd = 4; id_rs = 4; exp_q.push_back(ev_stall(3));
        tick(); clr(); mem_mem_read = 1; mem_rd = 4; id_rs = 4; ex_reg_write = 1; ex_rd = 4;
        exp_q.push_back(ev_run(0, FWD_REG, FWD_REG, 4));
        // Memory access: two frozen cycles, flush/stall/mem_req ignored meanwhile.
        tick(); clr(); mem_req = 1; exp_q.push_back(ev_run(0, FWD_REG, FWD_REG, 4));
        tick(); clr(); branch_taken = 1; mem_reg_write = 1; mem_rd = 2; ex_rt = 2;
        ex_mem_read = 1; ex_rd = 8; id_rs = 8;
        exp_q.push_back(ev(0, 0, 0, 0, 1, FWD_REG, FWD_EXMEM, 4, MEM_WAIT));
        tick(); clr(); branch_taken = 1; mem_req = 1;
        exp_q.push_back(ev(0, 0, 0, 0, 1, FWD_REG, FWD_REG, 5, MEM_WAIT));
        tick(); clr(); exp_q.push_back(ev_run(0, FWD_REG, FWD_REG, 6));
        // Reset in the second wait cycle aborts the access.
        tick(); clr(); mem_req = 1; exp_q.push_back(ev_run(0, FWD_REG, FWD_REG, 6));
        tick(); clr(); exp_q.push_back(ev(0, 0, 0, 0, 1, FWD_REG, FWD_REG, 6, MEM_WAIT));
        tick(); clr(); Reset = 1; exp_q.push_back(ev(0, 0, 1, 1, 0, FWD_REG, FWD_REG, 7, MEM_WAIT));
        tick(); clr(); Reset = 0; exp_q.push_back(ev_run(0, FWD_REG, FWD_REG, 0));
        tick(); clr(); ex_mem_read = 1; ex_rd = 8; id_rs = 8; exp_q.push_back(ev_stall(0));
        tick(); clr(); exp_q.push_back(ev_run(0, FWD_REG, FWD_REG, 1));

        // Zero-latency memory never freezes; 2-bit counter saturates at 3.
        tick(); s_mem_req = 1; exp2_q.push_back({1'b1, 1'b0, 2'd0});
        tick(); s_mem_req = 0; exp2_q.push_back({1'b1, 1'b0, 2'd0});
        s_ex_rd = 6; s_id_rs = 6;
        for (int i = 0; i < 5; i++) begin
            tick(); s_ex_mem_read = 1;
            exp2_q.push_back({1'b0, 1'b0, (i > 3) ? 2'd3 : 2'(i)});
        end
        tick(); s_ex_mem_read = 0; exp2_q.push_back({1'b1, 1'b0, 2'd3});
        tick(); Reset = 1; exp2_q.push_back({1'b0, 1'b0, 2'd3});
        tick(); Reset = 0; exp2_q.push_back({1'b1, 1'b0, 2'd0});

        for (int i = 0; i < 10 && (exp_q.size() > 0 || exp2_q.size() > 0); i++) @(negedge Clk);
        #1;
        if (exp_q.size() > 0 || exp2_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size() + exp2_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5: register-specifier width.
REQ-002 SHALL have parameter MEM_LAT, default 2: extra cycles per memory access (0..15); 0 means the access never freezes the pipeline.
REQ-003 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-004 SHALL have the port list below; one clock; reset is synchronous and active-high.
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- id_rs, id_rt  in  REG_W each  IF/ID source specifiers.
- id_uses_rt  in  1  IF/ID instruction reads rt.
- id_is_branch  in  1  IF/ID instruction is a branch resolved in ID.
- branch_taken  in  1  ID branch outcome.
- ex_rs, ex_rt, ex_rd  in  REG_W each  ID/EX specifiers.
- ex_reg_write, ex_mem_read  in  1 each  ID/EX control.
- mem_rd  in  REG_W;  mem_reg_write, mem_mem_read, mem_req  in  1 each  EX/MEM fields; mem_req = memory access starts.
- wb_rd  in  REG_W;  wb_reg_write  in  1  MEM/WB fields.
- pc_write, if_id_write  out  1 each  PC and IF/ID enables.
- id_ex_bubble  out  1  zero ID/EX control (insert nop).
- if_id_flush  out  1  squash IF/ID contents.
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-005 A specifier equal to 0 SHALL never match any hazard or forwarding comparison.
REQ-006 The FSM SHALL have states RUN and MEM_WAIT, plus a 4-bit down-counter wait_cnt.
REQ-007 RUN -> MEM_WAIT when mem_req=1 and MEM_LAT>0; on that edge wait_cnt SHALL load MEM_LAT.
REQ-008 In MEM_WAIT, wait_cnt SHALL decrement each cycle; MEM_WAIT -> RUN on the edge where wait_cnt=1.
REQ-009 In MEM_WAIT: pc_write=0, if_id_write=0, pipe_hold=1, id_ex_bubble=0, if_id_flush=0; branch_taken and mem_req are ignored.
REQ-010 Load-use stall (RUN) SHALL assert when ex_mem_read=1 and ex_rd matches id_rs, or matches id_rt with id_uses_rt=1.
REQ-011 Branch stall (RUN) SHALL assert when id_is_branch=1 and either:
- ex_reg_write=1 and ex_rd matches an ID source; or
- mem_mem_read=1 and mem_rd matches an ID source.
REQ-012 On any RUN stall: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, pipe_hold=0.
REQ-013 In RUN without stall, if_id_flush SHALL equal branch_taken.
- A stall takes priority over a flush in the same cycle.
- MEM_WAIT takes priority over both.
REQ-014 In RUN without stall: pc_write=1, if_id_write=1, id_ex_bubble=0, pipe_hold=0.
REQ-015 fwd_a SHALL be 10 if mem_reg_write=1 and mem_rd matches ex_rs; else 01 if wb_reg_write=1 and wb_rd matches ex_rs; else 00.
- fwd_b SHALL be identical, using ex_rt.
- fwd_a/fwd_b SHALL be combinational, valid in every state.
REQ-016 stall_count SHALL increment on each edge where pc_write=0, and hold at 2^CNT_W-1.
REQ-017 Hazard and forwarding outputs SHALL be combinational from inputs and state, with zero-cycle latency.

Reset
REQ-018 On an edge with Reset=1: state <= RUN, wait_cnt <= 0, stall_count <= 0; Reset mid-MEM_WAIT SHALL abort the wait.
REQ-019 While Reset=1:
- pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=1, pipe_hold=0, fwd_a=fwd_b=00.

Structure
REQ-020 FSM state encoding and forwarding-select constants (FWD_REG, FWD_EXMEM, FWD_MEMWB) SHALL live in shared package pipe_pkg.
REQ-021 The specifier comparator SHALL be sub-module reg_match (nonzero-and-equal), instantiated per comparison.

Verification
REQ-022 ex_mem_read=1, ex_rd=8, id_rs=8 -> one cycle pc_write=0, id_ex_bubble=1; stall_count 0->1.
REQ-023 ex_mem_read=1, ex_rd=0, id_rs=0 -> no stall; pc_write=1.
REQ-024 mem_reg_write=1, mem_rd=5; wb_reg_write=1, wb_rd=5; ex_rs=5 -> fwd_a=10 (EX/MEM wins).
REQ-025 MEM_LAT=2, single-cycle mem_req pulse -> pipe_hold=1, pc_write=0 for exactly 2 cycles, then RUN; branch_taken=1 during the wait -> if_id_flush stays 0.
REQ-026 id_is_branch=1, ex_reg_write=1, ex_rd=id_rt=3, branch_taken=1 -> stall with if_id_flush=0; next cycle, hazard gone -> if_id_flush=1.
REQ-027 Reset asserted in 2nd MEM_WAIT cycle -> next cycle state RUN, stall_count=0, pipe_hold=0.
